// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter sharing one slave bus between instruction fetch and data access.
// The data master has fixed priority from idle; a completing master always hands over to a waiting peer.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  output logic        if_err,

  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_sel,
  output logic [31:0] mem_rdata,
  output logic        mem_ack,
  output logic        mem_err,

  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_sel,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,

  output logic        stallreq
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_IF  = 2'd1,
    GNT_MEM = 2'd2
  } state_t;

  state_t     state, state_next;
  logic [7:0] wait_cnt;
  logic       granted;
  logic       timeout;
  logic       done;

  assign granted = (state != IDLE);
  assign timeout = granted && !bus_ack && (wait_cnt == 8'(TIMEOUT - 1));
  assign done    = granted && (bus_ack || timeout);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Cleared on every completion, so any GNT state is entered with a zero count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  wait_cnt <= 8'd0;
    else if (!granted || done) wait_cnt <= 8'd0;
    else                       wait_cnt <= wait_cnt + 8'd1;
  end

  // NOTE: default assignment up front keeps this combinational block free of inferred latches.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (mem_req)     state_next = GNT_MEM;
        else if (if_req) state_next = GNT_IF;
      end
      GNT_IF:  if (done) state_next = mem_req ? GNT_MEM : IDLE;
      GNT_MEM: if (done) state_next = if_req  ? GNT_IF  : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Responses are gated by the owner's request: a master that dropped req mid-cycle gets nothing back.
  always_comb begin
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = 32'd0;
    bus_wdata = 32'd0;
    bus_sel   = 4'd0;
    if_ack    = 1'b0;
    if_err    = 1'b0;
    if_rdata  = 32'd0;
    mem_ack   = 1'b0;
    mem_err   = 1'b0;
    mem_rdata = 32'd0;
    unique case (state)
      GNT_IF: begin
        bus_req  = 1'b1;
        bus_addr = if_addr;
        bus_sel  = 4'b1111;
        if (if_req) begin
          if_ack   = bus_ack;
          if_err   = timeout;
          if_rdata = bus_ack ? bus_rdata : 32'd0;
        end
      end
      GNT_MEM: begin
        bus_req   = 1'b1;
        bus_we    = mem_we;
        bus_addr  = mem_addr;
        bus_wdata = mem_wdata;
        bus_sel   = mem_sel;
        if (mem_req) begin
          mem_ack   = bus_ack;
          mem_err   = timeout;
          mem_rdata = bus_ack ? bus_rdata : 32'd0;
        end
      end
      default: ;
    endcase
  end

  assign stallreq = (if_req  & ~if_ack  & ~if_err)
                  | (mem_req & ~mem_ack & ~mem_err);

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL provide parameter TIMEOUT, default 16, meaning max cycles a granted transfer may wait for bus_ack (legal range 2..255).
REQ-002 SHALL provide port clk  input  1  single system clock; all state changes on rising edge.
REQ-003 SHALL provide port rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-004 SHALL provide if_req input 1, if_addr input 32: instruction-fetch master request and word address.
REQ-005 SHALL provide if_rdata output 32, if_ack output 1, if_err output 1: fetch read data, completion pulse, timeout pulse.
REQ-006 SHALL provide mem_req input 1, mem_we input 1, mem_addr input 32, mem_wdata input 32, mem_sel input 4: data master request, write enable, address, write data, byte lanes.
REQ-007 SHALL provide mem_rdata output 32, mem_ack output 1, mem_err output 1: data-master read data, completion pulse, timeout pulse.
REQ-008 SHALL provide bus_req output 1, bus_we output 1, bus_addr output 32, bus_wdata output 32, bus_sel output 4: shared slave-side request.
REQ-009 SHALL provide bus_rdata input 32, bus_ack input 1: slave read data and completion.
REQ-010 SHALL provide stallreq output 1: pipeline stall request to the stall controller.

Function
REQ-011 SHALL implement FSM states IDLE, GNT_IF, GNT_MEM, held in a registered state variable.
REQ-012 In IDLE, SHALL grant on next edge: mem_req -> GNT_MEM, else if_req -> GNT_IF, else stay IDLE (data master has fixed priority).
REQ-013 In GNT_IF, SHALL drive bus_req=1, bus_we=0, bus_addr=if_addr, bus_sel=4'b1111, bus_wdata=0.
REQ-014 In GNT_MEM, SHALL drive bus_req=1 and bus_we/addr/wdata/sel from the mem_* inputs.
REQ-015 In IDLE, SHALL drive all bus_* outputs to 0.
REQ-016 SHALL assert the granted master's ack combinationally in the same cycle bus_ack=1, with its rdata = bus_rdata; non-granted master's ack/rdata SHALL be 0.
REQ-017 On completion cycle, SHALL select next state with the completing master's request masked: the other master's request -> its GNT state directly (zero idle cycles), else IDLE.
REQ-018 Masters hold req and payload stable until ack or err; arbiter SHALL not latch payload.
REQ-019 SHALL maintain an 8-bit wait counter cleared on entry to any GNT state and incremented each GNT cycle without bus_ack.
REQ-020 When counter equals TIMEOUT-1 and bus_ack=0, SHALL pulse granted master's err for one cycle with ack=0, rdata=0, and transition per REQ-017 masking rule.
REQ-021 bus_ack in IDLE SHALL be ignored (no ack, no err, no state change).
REQ-022 stallreq SHALL equal (if_req & ~if_ack & ~if_err) | (mem_req & ~mem_ack & ~mem_err), combinational.
REQ-023 A master dropping req while granted (protocol violation) SHALL not abort the bus cycle; the arbiter SHALL complete it on ack/timeout and discard the response.

Reset
REQ-024 While rst=0, state SHALL be IDLE and counter 0 immediately (asynchronous), forcing all bus_*, *_ack, *_err outputs to 0.
REQ-025 Reset mid-transfer SHALL abandon the transfer without any ack or err pulse; first grant occurs on the first rising edge after rst returns to 1.

Verification
REQ-026 Reset: rst=0 during GNT_MEM with bus_req=1 -> bus_req=0 same cycle, no mem_ack; release -> IDLE.
REQ-027 Simultaneous: if_req=mem_req=1 in IDLE, slave acks after 2 cycles -> GNT_MEM first, mem_ack pulse, next cycle GNT_IF with bus_addr=if_addr, then if_ack.
REQ-028 Fairness: mem_req held continuously, if_req=1 -> grants alternate MEM, IF, MEM; IF never starved.
REQ-029 Write: mem_we=1, mem_addr=0x00000040, mem_wdata=0xDEADBEEF, mem_sel=4'b0011 -> bus outputs match exactly; stallreq=1 until mem_ack.
REQ-030 Timeout: TIMEOUT=4, if_req=1, bus_ack never -> if_err single pulse on 4th grant cycle, if_ack=0, if_rdata=0, then IDLE.
REQ-031 Stray ack: bus_ack=1 in IDLE with no requests -> no ack/err, state stays IDLE.
